sobel_window_gen: RTL and testbench



---
 rtl/gray_sobel_pkg.sv | 14 +
 rtl/sobel_line_buf.sv | 26 ++
 rtl/sobel_window_gen.sv | 114 +++++++++++
 tb/tb_sobel_window_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gray_sobel_pkg.sv
// Shared constants and helpers for the grayscale Sobel front end.
// Window element (r,c) lives at bit offset PX_BITS*win_idx(r,c).
package gray_sobel_pkg;

    localparam int unsigned PX_BITS        = 8;
    localparam int unsigned WIN_BITS       = 9 * PX_BITS;
    localparam int unsigned IMG_WIDTH_DEF  = 8;
    localparam int unsigned IMG_HEIGHT_DEF = 8;

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage: combinational read, clocked write to the same address,
// so a write-enabled cycle returns the previous line's value at that column.
module sobel_line_buf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data_c = mem[addr];

    // Contents need no reset: output validity gating hides stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 neighbourhood generator: two cascaded line buffers plus a shifting window,
// emitting one window per accepted pixel once the window lies fully inside the frame.
module sobel_window_gen #(
    parameter int unsigned IMG_WIDTH  = gray_sobel_pkg::IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = gray_sobel_pkg::IMG_HEIGHT_DEF,
    parameter int unsigned PX_BITS    = gray_sobel_pkg::PX_BITS
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 start_i,
    input  logic                 px_rdy_i,
    input  logic [PX_BITS-1:0]   px_i,
    output logic [9*PX_BITS-1:0] window_o,
    output logic                 px_rdy_o,
    output logic                 frame_done_o
);

    import gray_sobel_pkg::win_idx;

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
    localparam int unsigned WIN_W = 9 * PX_BITS;

    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [WIN_W-1:0]   win_sr;

    logic [COL_W-1:0]   col_cur_c;
    logic [ROW_W-1:0]   row_cur_c;
    logic               col_last_c;
    logic               row_last_c;
    logic               emit_c;
    logic [WIN_W-1:0]   win_base_c;
    logic [WIN_W-1:0]   win_next_c;
    logic [PX_BITS-1:0] lb0_rd_c;
    logic [PX_BITS-1:0] lb1_rd_c;

    // A start pulse makes the current pixel (0,0) of a fresh frame.
    assign col_cur_c  = start_i ? '0 : col;
    assign row_cur_c  = start_i ? '0 : row;
    assign col_last_c = (col_cur_c == COL_W'(IMG_WIDTH - 1));
    assign row_last_c = (row_cur_c == ROW_W'(IMG_HEIGHT - 1));
    assign emit_c     = px_rdy_i && (row_cur_c >= ROW_W'(2)) && (col_cur_c >= COL_W'(2));
    assign win_base_c = start_i ? '0 : win_sr;

    sobel_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PX_BITS)
    ) lb0 (
        .clk       (clk_i),
        .we        (px_rdy_i),
        .addr      (col_cur_c),
        .wr_data   (px_i),
        .rd_data_c (lb0_rd_c)
    );

    sobel_line_buf #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PX_BITS)
    ) lb1 (
        .clk       (clk_i),
        .we        (px_rdy_i),
        .addr      (col_cur_c),
        .wr_data   (lb0_rd_c),
        .rd_data_c (lb1_rd_c)
    );

    // Shift left one column; the new right column is {line y-2, line y-1, current pixel}.
    always_comb begin
        win_next_c = '0;
        for (int unsigned r = 0; r < 3; r++) begin
            for (int unsigned c = 0; c < 2; c++) begin
                win_next_c[PX_BITS*win_idx(r, c) +: PX_BITS] =
                    win_base_c[PX_BITS*win_idx(r, c + 1) +: PX_BITS];
            end
        end
        win_next_c[PX_BITS*win_idx(0, 2) +: PX_BITS] = lb1_rd_c;
        win_next_c[PX_BITS*win_idx(1, 2) +: PX_BITS] = lb0_rd_c;
        win_next_c[PX_BITS*win_idx(2, 2) +: PX_BITS] = px_i;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col          <= '0;
            row          <= '0;
            win_sr       <= '0;
            window_o     <= '0;
            px_rdy_o     <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            px_rdy_o     <= emit_c;
            frame_done_o <= emit_c && row_last_c && col_last_c;
            if (start_i) begin
                col      <= '0;
                row      <= '0;
                win_sr   <= '0;
                window_o <= '0;
            end
            if (px_rdy_i) begin
                win_sr <= win_next_c;
                if (col_last_c) begin
                    col <= '0;
                    row <= row_last_c ? '0 : row_cur_c + ROW_W'(1);
                end else begin
                    col <= col_cur_c + COL_W'(1);
                end
            end
            if (emit_c) begin
                window_o <= win_next_c;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a 2-D image model predicts every window,
// a negedge monitor checks strobes, windows, frame_done and one-cycle latency.
module tb_sobel_window_gen;

    localparam int unsigned WB = gray_sobel_pkg::WIN_BITS;

    typedef struct {
        logic [WB-1:0] win;
        logic          fd;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start4 = 1'b0, rdy4_i = 1'b0;
    logic [7:0]    px4 = 8'd0;
    logic [WB-1:0] win4;
    logic          rdy4, fd4;
    logic          start3 = 1'b0, rdy3_i = 1'b0;
    logic [7:0]    px3 = 8'd0;
    logic [WB-1:0] win3;
    logic          rdy3, fd3;

    int   nvec = 0, errs = 0, cyc = 0;
    int   nstrobe4 = 0, nstrobe3 = 0;
    exp_t q4[$], q3[$];
    int   pos4 = 0, pos3 = 0;
    int   img4 [4][4];
    int   img3 [3][3];

    sobel_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PX_BITS(8)) dut4 (
        .clk_i (clk), .nreset_i (nreset), .start_i (start4), .px_rdy_i (rdy4_i),
        .px_i (px4), .window_o (win4), .px_rdy_o (rdy4), .frame_done_o (fd4)
    );

    sobel_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PX_BITS(8)) dut3 (
        .clk_i (clk), .nreset_i (nreset), .start_i (start3), .px_rdy_i (rdy3_i),
        .px_i (px3), .window_o (win3), .px_rdy_o (rdy3), .frame_done_o (fd3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle decides whether a window is due and checks it.
    initial begin
        exp_t e;
        logic due4, due3;
        forever begin
            @(negedge clk);
            while (q4.size() > 0 && q4[0].due < cyc) void'(q4.pop_front());
            while (q3.size() > 0 && q3[0].due < cyc) void'(q3.pop_front());
            due4 = (q4.size() > 0) && (q4[0].due == cyc);
            due3 = (q3.size() > 0) && (q3[0].due == cyc);
            chk("px_rdy4", WB'(rdy4), WB'(due4));
            chk("px_rdy3", WB'(rdy3), WB'(due3));
            if (rdy4) nstrobe4++;
            if (rdy3) nstrobe3++;
            if (due4) begin
                e = q4.pop_front();
                chk("window4", win4, e.win);
                chk("frame_done4", WB'(fd4), WB'(e.fd));
            end else begin
                chk("frame_done4_idle", WB'(fd4), WB'(0));
            end
            if (due3) begin
                e = q3.pop_front();
                chk("window3", win3, e.win);
                chk("frame_done3", WB'(fd3), WB'(e.fd));
            end else begin
                chk("frame_done3_idle", WB'(fd3), WB'(0));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start4 = 1'b0; rdy4_i = 1'b0;
            start3 = 1'b0; rdy3_i = 1'b0;
        end
    endtask

    task automatic send4(input logic [7:0] v, input logic st);
        exp_t e;
        int y, x;
        @(posedge clk); #1;
        start4 = st; rdy4_i = 1'b1; px4 = v;
        start3 = 1'b0; rdy3_i = 1'b0;
        if (st) pos4 = 0;
        y = pos4 / 4;
        x = pos4 % 4;
        img4[y][x] = int'(v);
        if (y >= 2 && x >= 2) begin
            e.win = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[8*(3*r+c) +: 8] = 8'(img4[y-2+r][x-2+c]);
            e.fd  = (y == 3 && x == 3);
            e.due = cyc + 1;
            q4.push_back(e);
        end
        pos4 = (pos4 + 1) % 16;
    endtask

    task automatic send3(input logic [7:0] v);
        exp_t e;
        int y, x;
        @(posedge clk); #1;
        start3 = 1'b0; rdy3_i = 1'b1; px3 = v;
        start4 = 1'b0; rdy4_i = 1'b0;
        y = pos3 / 3;
        x = pos3 % 3;
        img3[y][x] = int'(v);
        if (y >= 2 && x >= 2) begin
            e.win = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.win[8*(3*r+c) +: 8] = 8'(img3[y-2+r][x-2+c]);
            e.fd  = (y == 2 && x == 2);
            e.due = cyc + 1;
            q3.push_back(e);
        end
        pos3 = (pos3 + 1) % 9;
    endtask

    initial begin
        int base;
        logic [WB-1:0] first_win;
        #12;
        chk("reset_window", win4, '0);
        chk("reset_px_rdy", WB'(rdy4), '0);
        chk("reset_frame_done", WB'(fd4), '0);
        @(posedge clk); #1;
        nreset = 1'b1;

        // Back-to-back frame 0..15
        base = nstrobe4;
        for (int i = 0; i < 16; i++) send4(8'(i), 1'b0);
        idle(3);
        chk("strobes_frame1", WB'(nstrobe4 - base), WB'(4));

        // Same stream with random gaps
        for (int i = 0; i < 16; i++) begin
            send4(8'(i), 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(3);

        // Two consecutive frames, no leakage
        for (int i = 0; i < 16; i++) send4(8'(i), 1'b0);
        for (int i = 100; i < 116; i++) send4(8'(i), 1'b0);
        idle(3);

        // Mid-frame restart carrying pixel 50
        base = nstrobe4;
        for (int i = 0; i < 10; i++) send4(8'(i), 1'b0);
        send4(8'd50, 1'b1);
        for (int i = 51; i < 66; i++) send4(8'(i), 1'b0);
        idle(3);
        chk("strobes_restart", WB'(nstrobe4 - base), WB'(4));

        // Asynchronous reset just after an emission
        for (int i = 0; i < 11; i++) send4(8'(i), 1'b0);
        @(posedge clk); #1;
        rdy4_i = 1'b0; start4 = 1'b0;
        #2;
        nreset = 1'b0;
        q4.delete();
        pos4 = 0;
        #1;
        chk("async_rst_window", win4, '0);
        chk("async_rst_px_rdy", WB'(rdy4), '0);
        chk("async_rst_frame_done", WB'(fd4), '0);
        repeat (2) @(posedge clk);
        #3;
        nreset = 1'b1;
        base = nstrobe4;
        for (int i = 0; i < 16; i++) send4(8'(i), 1'b0);
        idle(3);
        chk("strobes_after_reset", WB'(nstrobe4 - base), WB'(4));

        // 3x3 image: single window 1..9
        base = nstrobe3;
        first_win = '0;
        for (int i = 0; i < 9; i++) begin
            send3(8'(i + 1));
            first_win[8*i +: 8] = 8'(i + 1);
        end
        idle(1);
        #4;
        chk("win3_single", win3, first_win);
        idle(3);
        chk("strobes_3x3", WB'(nstrobe3 - base), WB'(1));

        // Random pixels, random gaps, occasional restart
        for (int i = 0; i < 300; i++) begin
            send4(8'($urandom_range(0, 255)), 1'($urandom_range(0, 19) == 0));
            idle($urandom_range(0, 2));
        end
        idle(5);

        chk("q4_drained", WB'(q4.size()), '0);
        chk("q3_drained", WB'(q3.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
